aes_word_stream_if: RTL and testbench



---
 rtl/aes_word_stream_if.sv | 265 ++++++++++++++++++++++++++
 tb/tb_aes_word_stream_if.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_word_stream_if.sv
// aes_word_stream_if
//   Adapter in front of a 128-bit AES encryption core. A 32-bit valid/ready
//   word stream first loads the key and then plaintext blocks. Each quantity
//   is sent most-significant word first. For each block the adapter pulses
//   aes_start and waits for aes_done. It captures the ciphertext and streams
//   it out as four 32-bit words, [127:96] first.
//
//   Optional feature, macro AES_CBC_EN:
//     - an IV is loaded after the key into a chain register;
//     - the core sees plaintext ^ chain;
//     - each good ciphertext becomes the next chain value.
//   With the macro undefined there is no IV state and the plaintext goes
//   straight to the core.
//
// Parameters
//   DONE_TIMEOUT  cycles allowed in WAIT before the core is declared hung (>= 16)
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   s_valid/s_ready/s_data/rekey   input word stream; rekey reloads the key
//   m_valid/m_ready/m_data/m_last  ciphertext word stream
//   aes_start/aes_key/aes_plaintext   drive the core
//   aes_done/aes_ciphertext           core result
//   busy            high while a block is in START/WAIT/OUT
//   timeout_err     sticky hung-core flag, cleared only by reset
module aes_word_stream_if #(
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         rekey,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         aes_start,
  output logic [127:0] aes_key,
  output logic [127:0] aes_plaintext,
  input  logic         aes_done,
  input  logic [127:0] aes_ciphertext,
  output logic         busy,
  output logic         timeout_err
);

  localparam int unsigned TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_KEY   = 3'd0,
    ST_PT    = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
`ifdef AES_CBC_EN
    ST_IV    = 3'd5,
`endif
    ST_OUT   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   ct_q, ct_d;
  logic [127:0]   key_d, ptx_d;
  logic           m_valid_d, m_last_d, start_d, busy_d, terr_d;
  logic [31:0]    m_data_d;
  logic           in_hs;
`ifdef AES_CBC_EN
  logic [127:0]   chain_q, chain_d;
`endif

  // Insert word k of a 128-bit quantity (word 0 is [127:96]).
  function automatic logic [127:0] put_word(input logic [127:0] q,
                                            input logic [1:0] k,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = q;
    case (k)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // Extract word k of a 128-bit quantity (word 0 is [127:96]).
  function automatic logic [31:0] get_word(input logic [127:0] q,
                                           input logic [1:0] k);
    case (k)
      2'd0:    return q[127:96];
      2'd1:    return q[95:64];
      2'd2:    return q[63:32];
      default: return q[31:0];
    endcase
  endfunction

  // Input acceptance. A rekey request at a block boundary blocks the word.
  always_comb begin
    s_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_KEY:  s_ready = 1'b1;
`ifdef AES_CBC_EN
        ST_IV:   s_ready = 1'b1;
`endif
        ST_PT:   s_ready = !((cnt_q == 2'd0) && rekey);
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign in_hs = s_valid && s_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    key_d     = aes_key;
    ptx_d     = aes_plaintext;
    m_valid_d = m_valid;
    m_data_d  = m_data;
    m_last_d  = m_last;
    terr_d    = timeout_err;
`ifdef AES_CBC_EN
    chain_d   = chain_q;
`endif

    case (state_q)
      ST_KEY: begin
        if (in_hs) begin
          key_d = put_word(aes_key, cnt_q, s_data);
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef AES_CBC_EN
            state_d = ST_IV;
`else
            state_d = ST_PT;
`endif
          end
        end
      end
`ifdef AES_CBC_EN
      ST_IV: begin
        if (in_hs) begin
          chain_d = put_word(chain_q, cnt_q, s_data);
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_PT;
        end
      end
`endif
      ST_PT: begin
        if ((cnt_q == 2'd0) && rekey) begin
          state_d = ST_KEY;
        end else if (in_hs) begin
          pt_d  = put_word(pt_q, cnt_q, s_data);
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef AES_CBC_EN
            ptx_d = pt_d ^ chain_q;
`else
            ptx_d = pt_d;
`endif
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (aes_done) begin
          ct_d      = aes_ciphertext;
          idx_d     = 2'd0;
          m_valid_d = 1'b1;
          m_data_d  = get_word(aes_ciphertext, 2'd0);
          m_last_d  = 1'b0;
          state_d   = ST_OUT;
`ifdef AES_CBC_EN
          chain_d   = aes_ciphertext;
`endif
        end else if (timer_q == TIMER_LAST) begin
          // Hung core: drop the block and wait for the next one.
          terr_d  = 1'b1;
          cnt_d   = 2'd0;
          state_d = ST_PT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_OUT: begin
        if (m_valid && m_ready) begin
          if (idx_q == 2'd3) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            cnt_d     = 2'd0;
            state_d   = ST_PT;
          end else begin
            idx_d    = idx_q + 2'd1;
            m_data_d = get_word(ct_q, idx_q + 2'd1);
            m_last_d = (idx_q == 2'd2);
          end
        end
      end
      default: begin
        state_d = ST_KEY;
        cnt_d   = 2'd0;
      end
    endcase

    start_d = (state_d == ST_START);
    busy_d  = (state_d == ST_START) || (state_d == ST_WAIT) || (state_d == ST_OUT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_KEY;
      cnt_q         <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      pt_q          <= '0;
      ct_q          <= '0;
      aes_key       <= '0;
      aes_plaintext <= '0;
      aes_start     <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef AES_CBC_EN
      chain_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      pt_q          <= pt_d;
      ct_q          <= ct_d;
      aes_key       <= key_d;
      aes_plaintext <= ptx_d;
      aes_start     <= start_d;
      m_valid       <= m_valid_d;
      m_data        <= m_data_d;
      m_last        <= m_last_d;
      busy          <= busy_d;
      timeout_err   <= terr_d;
`ifdef AES_CBC_EN
      chain_q       <= chain_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_word_stream_if.sv
// Self-checking bench for aes_word_stream_if. The bench plays the AES core:
// FIPS-197 key/plaintext returns the FIPS ciphertext, and any other input
// returns a fixed mixing function. Expected core inputs and output words are
// queued by the stimulus and compared by independent monitors.
module tb_aes_word_stream_if;

  localparam int unsigned TO = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         rekey = 1'b0;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_plaintext;
  logic         aes_done;
  logic [127:0] aes_ciphertext;
  logic         busy;
  logic         timeout_err;

  logic         core_done = 1'b0;
  logic         spur_done = 1'b0;
  logic [127:0] core_ct = '0;
  logic [127:0] spur_ct = '0;
  logic         core_hang = 1'b0;
  logic         mr_auto = 1'b0;
  logic         mr_manual = 1'b0;
  int           mr_mode = 2;      // 0 random, 1 toggle, 2 manual
  int           gap_max = 0;

  assign aes_done       = core_done | spur_done;
  assign aes_ciphertext = spur_done ? spur_ct : core_ct;
  assign m_ready        = (mr_mode == 2) ? mr_manual : mr_auto;

  aes_word_stream_if #(.DONE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .rekey(rekey),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .aes_start(aes_start), .aes_key(aes_key), .aes_plaintext(aes_plaintext),
    .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic last; } out_t;
  typedef struct packed { logic [127:0] key; logic [127:0] pt; } start_t;

  out_t   out_q[$];
  start_t start_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int exp_starts = 0;
  logic [127:0] key_m = '0;
  logic [127:0] chain_m = '0;
  logic         terr_m = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in cipher: exact FIPS-197 result for the FIPS vector, mixing otherwise.
  function automatic logic [127:0] fake_enc(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {k[95:0], k[127:96]} ^ {p[63:0], p[127:64]} ^ 128'hc3a5_0f1e_9687_2d4b_5a5a_e1d2_7b3c_4f60;
  endfunction

  // Downstream ready generator.
  initial forever begin
    @(posedge clk); #1;
    if (mr_mode == 0) mr_auto = ($urandom_range(0, 3) != 0);
    else if (mr_mode == 1) mr_auto = ~mr_auto;
  end

  // Core model: checks what the adapter presents, then answers after a delay.
  initial begin
    logic [127:0] k, p;
    start_t s;
    int d;
    forever begin
      @(negedge clk);
      if (!reset && aes_start) begin
        start_cnt++;
        k = aes_key;
        p = aes_plaintext;
        if (start_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_start: got aes_start=1 expected no start");
        end else begin
          s = start_q.pop_front();
          chk128("aes_key", k, s.key);
          chk128("aes_plaintext", p, s.pt);
        end
        if (!core_hang) begin
          d = $urandom_range(1, 8);
          repeat (d) @(posedge clk);
          #1;
          chk128("key_stable", aes_key, k);
          chk128("pt_stable", aes_plaintext, p);
          core_done = 1'b1;
          core_ct   = fake_enc(k, p);
          @(posedge clk); #1;
          core_done = 1'b0;
          core_ct   = rand128();
          @(negedge clk);
          chk1("m_valid_latency", m_valid, 1'b1);
        end
      end
    end
  end

  // Output monitor: scoreboard pops on handshake, plus stall/busy invariants.
  initial begin
    logic prev_stall, prev_start, prev_last;
    logic [31:0] prev_data;
    out_t e;
    prev_stall = 1'b0; prev_start = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (m_valid) begin
          chk1("busy_in_out", busy, 1'b1);
          chk1("s_ready_in_out", s_ready, 1'b0);
          if (prev_stall) begin
            chk32("stall_data", m_data, prev_data);
            chk1("stall_last", m_last, prev_last);
          end
          if (m_ready) begin
            if (out_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_output: got %h expected no word", m_data);
            end else begin
              e = out_q.pop_front();
              chk32("m_data", m_data, e.data);
              chk1("m_last", m_last, e.last);
            end
          end
        end
        if (aes_start) begin
          chk1("s_ready_in_start", s_ready, 1'b0);
          chk1("busy_in_start", busy, 1'b1);
          chk1("start_width", prev_start, 1'b0);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        prev_start = aes_start;
      end
    end
  end

  // Every stimulus task begins and ends one time step after a rising edge.
  task automatic send_word(input logic [31:0] w);
    int n;
    logic hs;
    s_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = w;
    n = 0; hs = 1'b0;
    while (!hs && n < 300) begin @(negedge clk); hs = s_ready; n++; end
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL s_ready_timeout: word %h not accepted, required acceptance", w);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic send_quad(input logic [127:0] q);
    for (int i = 0; i < 4; i++) send_word(q[127-32*i -: 32]);
  endtask

  task automatic load_key(input logic [127:0] key, input logic [127:0] iv);
    send_quad(key);
`ifdef AES_CBC_EN
    send_quad(iv);
`endif
    key_m   = key;
    chain_m = iv;
  endtask

  task automatic send_block(input logic [127:0] pt, input logic hang, input logic mid_rekey);
    logic [127:0] ap, ct;
    start_t s;
    out_t o;
    ap = pt ^ (CBC ? chain_m : 128'h0);
    s.key = key_m;
    s.pt  = ap;
    start_q.push_back(s);
    exp_starts++;
    core_hang = hang;
    if (!hang) begin
      ct = fake_enc(key_m, ap);
      for (int i = 0; i < 4; i++) begin
        o.data = ct[127-32*i -: 32];
        o.last = (i == 3);
        out_q.push_back(o);
      end
      chain_m = ct;
    end
    for (int i = 0; i < 4; i++) begin
      if (mid_rekey && i == 2) rekey = 1'b1;
      send_word(pt[127-32*i -: 32]);
    end
    rekey = 1'b0;
    @(negedge clk);
    chk1("start_latency", aes_start, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, required idle", busy, out_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle();
    chk1("idle_s_ready", s_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_m_valid", m_valid, 1'b0);
    chk1("idle_timeout_err", timeout_err, terr_m);
  endtask

  task automatic check_reset_vals();
    chk1("rst_m_valid", m_valid, 1'b0);
    chk32("rst_m_data", m_data, 32'h0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_aes_start", aes_start, 1'b0);
    chk128("rst_aes_key", aes_key, 128'h0);
    chk128("rst_aes_plaintext", aes_plaintext, 128'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b1);
  endtask

  // Rekey at a block boundary: the offered word must not be taken.
  task automatic rekey_now();
    rekey   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hdead_beef;
    @(negedge clk);
    chk1("rekey_blocks_word", s_ready, 1'b0);
    @(posedge clk); #1;
    rekey   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk1("rekey_key_ready", s_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [127:0] k2;
    // Reset and reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b1;
    @(negedge clk);
    chk1("s_ready_in_reset", s_ready, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;

    // FIPS-197 vector, no backpressure
    mr_mode = 2; mr_manual = 1'b1;
    load_key(FIPS_KEY, 128'h0);
    chk128("key_loaded", aes_key, FIPS_KEY);
    send_block(FIPS_PT, 1'b0, 1'b0);
    wait_idle();
    check_idle();

    // Same plaintext again with toggling ready and input gaps
    gap_max = 3; mr_mode = 1;
    send_block(FIPS_PT, 1'b0, 1'b0);
    wait_idle();
    check_idle();

    // Random blocks, random ready, one mid-run key change
    mr_mode = 0;
    for (int b = 0; b < 5; b++) begin
      if (b == 2) begin
        rekey_now();
        load_key(rand128(), rand128());
      end
      send_block(rand128(), 1'b0, 1'b0);
      wait_idle();
    end
    check_idle();

    // Rekey at count 0 then a block with the new key
    rekey_now();
    k2 = rand128();
    load_key(k2, rand128());
    chk128("rekey_new_key", aes_key, k2);
    send_block(rand128(), 1'b0, 1'b0);
    wait_idle();

    // Rekey at count 2 is ignored
    send_block(rand128(), 1'b0, 1'b1);
    wait_idle();
    check_idle();

    // Hung core: exact timeout, then spurious done, then a normal block
    send_block(rand128(), 1'b1, 1'b0);
    repeat (TO) @(negedge clk);
    chk1("terr_before_timeout", timeout_err, 1'b0);
    chk1("busy_before_timeout", busy, 1'b1);
    @(negedge clk);
    terr_m = 1'b1;
    chk1("terr_after_timeout", timeout_err, 1'b1);
    chk1("busy_after_timeout", busy, 1'b0);
    chk1("no_output_on_timeout", m_valid, 1'b0);
    chk1("pt_after_timeout", s_ready, 1'b1);
    @(posedge clk); #1;
    core_hang = 1'b0;
    spur_ct   = rand128();
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk1("spurious_done_ignored", m_valid, 1'b0);
    end
    @(posedge clk); #1;
    send_block(rand128(), 1'b0, 1'b0);
    wait_idle();
    check_idle();

    // Reset during OUT at word index 2
    gap_max = 0; mr_mode = 2; mr_manual = 1'b0;
    send_block(rand128(), 1'b0, 1'b0);
    n = 0;
    while (!m_valid && n < 100) begin @(negedge clk); n++; end
    chk1("reached_out", m_valid, 1'b1);
    @(posedge clk); #1;
    mr_manual = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    mr_manual = 1'b0;
    @(negedge clk);
    chk32("out_idx2_data", m_data, (out_q.size() > 0) ? out_q[0].data : 32'h0);
    chk1("out_idx2_pending", (out_q.size() == 2) ? 1'b1 : 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("s_ready_mid_reset", s_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_q.delete();
    start_q.delete();
    key_m = '0; chain_m = '0; terr_m = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    mr_manual = 1'b1;
    k2 = rand128();
    load_key(k2, 128'h0);
    repeat (5) @(posedge clk);
    #1;
    chk32("no_start_before_block", 32'(start_cnt), 32'(exp_starts));
    chk128("post_reset_key", aes_key, k2);
    send_block(rand128(), 1'b0, 1'b0);
    wait_idle();
    check_idle();

    chk32("start_count", 32'(start_cnt), 32'(exp_starts));
    chk32("outputs_drained", 32'(out_q.size()), 32'h0);
    chk32("starts_drained", 32'(start_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
